oam_dma_ctrl: RTL and testbench

Sprite-DMA controller and CPU-bus arbiter for the NES core, placed between the T65 CPU and the databus.
- A CPU write to $4014 latches a source page.
- The block then stalls the CPU through Rdy and takes ownership of the bus.
- It copies the 256 bytes at $XX00-$XXFF to the PPU OAM data port $2004 as alternating read/write cycles.
- When the copy is done it returns the bus to the CPU.

---
 rtl/nes_pkg.sv | 27 ++
 rtl/oam_dma_ctrl.sv | 132 +++++++++++++
 tb/tb_oam_dma_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared NES bus constants and the sprite-DMA state type.
//   NES_ADDR_W          : width of the CPU/databus address
//   NES_DATA_W          : width of the CPU/databus data
//   NES_DECODE_W        : address bits actually decoded on the NES map
//   NES_PAGE_REG_ADDR   : CPU write address that starts a sprite DMA
//   NES_OAM_DATA_ADDR   : PPU OAM data port, destination of every DMA write
// ---------------------------------------------------------------------------
package nes_pkg;

    localparam int NES_ADDR_W   = 24;
    localparam int NES_DATA_W   = 8;
    localparam int NES_DECODE_W = 16;

    localparam logic [15:0] NES_PAGE_REG_ADDR = 16'h4014;
    localparam logic [15:0] NES_OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage : nes_pkg

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// Sprite-DMA controller and CPU/databus arbiter. A CPU write to the page
// register latches a source page; the CPU is then stalled while 256 bytes
// from $XX00-$XXFF are copied to the PPU OAM data port as alternating
// read/write cycles, after which the bus returns to the CPU.
//
// Ports:
//   CLK_NES    in   CPU clock, all state updates on rising edge
//   RESET      in   synchronous, active-high reset
//   CPU_ADDR   in   CPU address
//   CPU_WR     in   CPU R/W_n (1 = read, 0 = write)
//   CPU_DO     in   CPU write data
//   BUS_DI     in   databus read data, valid with BUS_ADDR
//   CPU_RDY    out  CPU ready, 0 stalls the CPU
//   BUS_ADDR   out  arbitrated address
//   BUS_WR     out  arbitrated R/W_n
//   BUS_DO     out  arbitrated write data
//   DMA_ACTIVE out  1 while DMA owns the bus
//
// state | meaning
// IDLE  | CPU owns the bus, BUS_* follow CPU_*
// HALT  | first stall cycle, no bus write
// ALIGN | extra stall cycle when HALT lands on an odd CPU cycle
// READ  | read byte {page, idx} into data_q
// WRITE | write data_q to OAM data port, advance idx or finish
// ---------------------------------------------------------------------------
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter int          ADDR_W        = NES_ADDR_W,
    parameter logic [15:0] PAGE_REG_ADDR = NES_PAGE_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR
) (
    input  logic              CLK_NES,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic              CPU_WR,
    input  logic [7:0]        CPU_DO,
    input  logic [7:0]        BUS_DI,
    output logic              CPU_RDY,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_WR,
    output logic [7:0]        BUS_DO,
    output logic              DMA_ACTIVE
);

    localparam int PAD_W = ADDR_W - NES_DECODE_W;

    dma_state_t state, state_nx;
    logic [7:0] page_q;
    logic [7:0] idx_q;
    logic [7:0] data_q;
    logic       parity_q;
    logic       trig;

    assign trig = (state == IDLE) && !CPU_WR &&
                  (CPU_ADDR[NES_DECODE_W-1:0] == PAGE_REG_ADDR);

    // state register
    always_ff @(posedge CLK_NES) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // datapath registers
    always_ff @(posedge CLK_NES) begin
        if (RESET) begin
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            // free-running CPU-cycle parity, independent of DMA state
            parity_q <= ~parity_q;
            case (state)
                IDLE: begin
                    if (trig) begin
                        page_q <= CPU_DO;
                        idx_q  <= 8'h00;
                    end
                end
                READ:  data_q <= BUS_DI;
                WRITE: idx_q  <= (idx_q == 8'hFF) ? 8'h00 : idx_q + 8'd1;
                default: ;
            endcase
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trig) state_nx = HALT;
            HALT:    state_nx = parity_q ? ALIGN : READ;
            ALIGN:   state_nx = READ;
            READ:    state_nx = WRITE;
            WRITE:   state_nx = (idx_q == 8'hFF) ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    // output mux
    always_comb begin
        DMA_ACTIVE = (state != IDLE);
        CPU_RDY    = ~DMA_ACTIVE;
        BUS_ADDR   = CPU_ADDR;
        BUS_WR     = CPU_WR;
        BUS_DO     = CPU_DO;
        case (state)
            IDLE: ;
            HALT, ALIGN: begin
                // dummy cycles keep the CPU address but never write
                BUS_ADDR = CPU_ADDR;
                BUS_WR   = 1'b1;
                BUS_DO   = data_q;
            end
            READ: begin
                BUS_ADDR = {{PAD_W{1'b0}}, page_q, idx_q};
                BUS_WR   = 1'b1;
                BUS_DO   = data_q;
            end
            WRITE: begin
                BUS_ADDR = {{PAD_W{1'b0}}, OAM_DATA_ADDR};
                BUS_WR   = 1'b0;
                BUS_DO   = data_q;
            end
            default: ;
        endcase
    end

endmodule : oam_dma_ctrl

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

    localparam int          ADDR_W    = 24;
    localparam logic [23:0] IDLE_ADDR = 24'h12_8000;

    logic              CLK_NES = 1'b0;
    logic              RESET   = 1'b1;
    logic [ADDR_W-1:0] CPU_ADDR = IDLE_ADDR;
    logic              CPU_WR   = 1'b1;
    logic [7:0]        CPU_DO   = 8'h00;
    logic [7:0]        BUS_DI;
    logic              CPU_RDY;
    logic [ADDR_W-1:0] BUS_ADDR;
    logic              BUS_WR;
    logic [7:0]        BUS_DO;
    logic              DMA_ACTIVE;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_q [$];
    logic       tb_par = 1'b0;
    int         checks = 0;
    int         errors = 0;

    oam_dma_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK_NES    (CLK_NES),
        .RESET      (RESET),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WR     (CPU_WR),
        .CPU_DO     (CPU_DO),
        .BUS_DI     (BUS_DI),
        .CPU_RDY    (CPU_RDY),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_WR     (BUS_WR),
        .BUS_DO     (BUS_DO),
        .DMA_ACTIVE (DMA_ACTIVE)
    );

    always #5 CLK_NES = ~CLK_NES;

    assign BUS_DI = mem[BUS_ADDR[15:0]];

    // CPU-cycle parity reference: cleared by reset, toggles every cycle
    always @(posedge CLK_NES) tb_par <= RESET ? 1'b0 : ~tb_par;

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK_NES);
        @(negedge CLK_NES);
        checks++;
        if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b active=%b required rdy=1 active=0", CPU_RDY, DMA_ACTIVE);
        end
        @(posedge CLK_NES); #1;
        RESET = 1'b0;
    endtask

    task automatic test_idle_passthrough();
        @(posedge CLK_NES); #1;
        CPU_ADDR = 24'h00_0123; CPU_WR = 1'b0; CPU_DO = 8'h5A;
        @(negedge CLK_NES);
        checks++;
        if (BUS_ADDR !== 24'h00_0123 || BUS_WR !== 1'b0 || BUS_DO !== 8'h5A || CPU_RDY !== 1'b1) begin
            errors++;
            $display("FAIL idle_passthrough addr=%h wr=%b do=%h rdy=%b required 000123 0 5a 1",
                     BUS_ADDR, BUS_WR, BUS_DO, CPU_RDY);
        end
        @(posedge CLK_NES); #1;
        CPU_ADDR = IDLE_ADDR; CPU_WR = 1'b1; CPU_DO = 8'h00;
    endtask

    // Triggers a DMA of 'page' so that HALT falls on parity 'odd', then
    // runs it to completion (or to write number 'abort_at' when nonzero,
    // where RESET is asserted during that write).
    task automatic run_dma(input logic [7:0] page, input bit odd, input int abort_at);
        int stall, nrd, nwr, first_rd;
        bit done, act_bad;
        logic [23:0] exp_addr;
        logic [7:0]  exp_d;
        stall = 0; nrd = 0; nwr = 0; first_rd = -1; done = 0; act_bad = 0;

        @(posedge CLK_NES); #1;
        if (tb_par == odd) begin @(posedge CLK_NES); #1; end
        for (int i = 0; i < 256; i++) exp_q.push_back(mem[{page, i[7:0]}]);
        CPU_ADDR = 24'h00_4014; CPU_WR = 1'b0; CPU_DO = page;
        @(negedge CLK_NES);
        checks++;
        if (BUS_ADDR !== 24'h00_4014 || BUS_WR !== 1'b0 || BUS_DO !== page || CPU_RDY !== 1'b1) begin
            errors++;
            $display("FAIL trigger_passthrough addr=%h wr=%b do=%h rdy=%b required 004014 0 %h 1",
                     BUS_ADDR, BUS_WR, BUS_DO, CPU_RDY, page);
        end
        @(posedge CLK_NES); #1;
        CPU_ADDR = IDLE_ADDR; CPU_WR = 1'b1; CPU_DO = 8'h00;

        for (int b = 0; b < 600; b++) begin
            @(negedge CLK_NES);
            if (CPU_RDY === 1'b1) begin done = 1; break; end
            stall++;
            if (DMA_ACTIVE !== 1'b1) act_bad = 1;
            if (BUS_WR === 1'b1 && BUS_ADDR[23:16] == 8'h00) begin
                if (first_rd < 0) first_rd = stall;
                exp_addr = {8'h00, page, nrd[7:0]};
                checks++;
                if (BUS_ADDR !== exp_addr || nrd > 255) begin
                    errors++;
                    $display("FAIL read_addr n=%0d addr=%h required %h", nrd, BUS_ADDR, exp_addr);
                end
                nrd++;
            end else if (BUS_WR === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL oam_write_extra n=%0d addr=%h data=%h required no write", nwr, BUS_ADDR, BUS_DO);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (BUS_ADDR !== 24'h00_2004 || BUS_DO !== exp_d) begin
                        errors++;
                        $display("FAIL oam_write n=%0d addr=%h data=%h required 002004 %h",
                                 nwr, BUS_ADDR, BUS_DO, exp_d);
                    end
                end
                nwr++;
                if (abort_at != 0 && nwr == abort_at) begin
                    RESET = 1'b1;
                    @(posedge CLK_NES); #1;
                    RESET = 1'b0;
                    exp_q.delete();
                    @(negedge CLK_NES);
                    checks++;
                    if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_release rdy=%b active=%b required 1 0", CPU_RDY, DMA_ACTIVE);
                    end
                    for (int k = 0; k < 20; k++) begin
                        @(negedge CLK_NES);
                        checks++;
                        if (BUS_WR !== 1'b1 || CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
                            errors++;
                            $display("FAIL abort_quiet cyc=%0d wr=%b rdy=%b active=%b required 1 1 0",
                                     k, BUS_WR, CPU_RDY, DMA_ACTIVE);
                        end
                    end
                    return;
                end
            end
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL dma_timeout stall=%0d required finish within 600 cycles", stall);
        end
        checks++;
        if (stall != 513 + int'(odd)) begin
            errors++;
            $display("FAIL stall_len page=%h stall=%0d required %0d", page, stall, 513 + int'(odd));
        end
        checks++;
        if (first_rd != 2 + int'(odd)) begin
            errors++;
            $display("FAIL first_read_cycle page=%h got=%0d required %0d", page, first_rd, 2 + int'(odd));
        end
        checks++;
        if (nrd != 256 || nwr != 256 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL transfer_count reads=%0d writes=%0d left=%0d required 256 256 0",
                     nrd, nwr, exp_q.size());
        end
        checks++;
        if (act_bad || DMA_ACTIVE !== 1'b0) begin
            errors++;
            $display("FAIL dma_active_flag during_bad=%b after=%b required 0 0", act_bad, DMA_ACTIVE);
        end
        exp_q.delete();
    endtask

    task automatic test_even_dma();   run_dma(8'h02, 1'b0, 0); endtask
    task automatic test_odd_dma();    run_dma(8'h05, 1'b1, 0); endtask
    task automatic test_page_wrap();  run_dma(8'hFF, 1'b0, 0); endtask

    task automatic test_reset_mid();
        run_dma(8'h07, 1'b0, 100);
        run_dma(8'h03, 1'b1, 0);
    endtask

    task automatic test_non_triggers();
        logic [23:0] addrs [2];
        logic        wrs   [2];
        addrs[0] = 24'h00_4014; wrs[0] = 1'b1;
        addrs[1] = 24'h00_4015; wrs[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(posedge CLK_NES); #1;
            CPU_ADDR = addrs[t]; CPU_WR = wrs[t]; CPU_DO = 8'h09;
            @(posedge CLK_NES); #1;
            CPU_ADDR = IDLE_ADDR; CPU_WR = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK_NES);
                checks++;
                if (CPU_RDY !== 1'b1 || DMA_ACTIVE !== 1'b0) begin
                    errors++;
                    $display("FAIL non_trigger t=%0d cyc=%0d rdy=%b active=%b required 1 0",
                             t, k, CPU_RDY, DMA_ACTIVE);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_dma(8'h10, 1'b1, 0);
        run_dma(8'h11, 1'b0, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        test_reset();
        test_idle_passthrough();
        test_even_dma();
        test_odd_dma();
        test_page_wrap();
        test_reset_mid();
        test_non_triggers();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_oam_dma_ctrl
